ps2_frame_controller: RTL and testbench
=======================================

// Module: ps2_frame_controller
// PURPOSE
//  Sequences PS/2 keyboard reception in the FPGA clock domain.
//  - Synchronises and de-glitches the raw keyboard clock and data lines.
//  - Frames each 11-bit word: start, 8 data bits LSB-first, odd parity, stop.
//  - Checks parity, stop bit and inter-bit timeout.
//  - Folds E0/F0 prefixes into flags and delivers one key event per code on a valid/ready port.
// PARAMETERS
//  FILTER_LEN      4       consecutive equal samples needed to accept a keyboard clock level change
//  TIMEOUT_CYCLES  100000  max Clock cycles between falling edges inside a frame
// PORTS
//  Clock           in   1  FPGA system clock; all logic on rising edge
//  iReset          in   1  synchronous, active-low reset
//  iClockTeclado   in   1  raw PS/2 clock from keyboard, asynchronous
//  iDataTeclado    in   1  raw PS/2 data from keyboard, asynchronous
//  iReady          in   1  consumer accepts the event when oValid & iReady
//  oValid          out  1  key event available; held until accepted
//  oCode           out  8  scan code, prefixes removed
//  oExtended       out  1  code was preceded by E0
//  oBreak          out  1  code was preceded by F0 (key release)
//  oParityError    out  1  1-cycle pulse: frame discarded, bad parity
//  oFrameError     out  1  1-cycle pulse: frame discarded, stop=0 or timeout
//  oOverrun        out  1  1-cycle pulse: completed event dropped, output register full
//  oBusy           out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (iReset=0 at a Clock edge):
//    - All outputs, shift register, bit counter, timeout counter and prefix flags go to 0.
//    - FSM goes to IDLE. A frame in progress is discarded.
//  - Input conditioning:
//    - Both inputs pass through 2 synchroniser FFs.
//    - Filtered clock changes level only after FILTER_LEN consecutive synchronised samples at the new level.
//    - A fall event is one Clock cycle in which the filtered clock goes 1->0.
//    - Data is sampled from the synchronised data line in that same cycle.
//  - FSM transitions:
//    - IDLE: on a fall with data=0, go to DATA and set bitcnt=0. On a fall with data=1, stay in IDLE (no error).
//    - DATA: on each fall, shift data in LSB-first. After bit 7 is sampled (bitcnt==7), go to PARITY.
//    - PARITY: store the bit, go to STOP.
//    - STOP, data=1 and XOR(d[7:0],parity)=1: byte complete, go to IDLE.
//    - STOP, bad parity: pulse oParityError, clear both prefix flags, go to IDLE. Parity takes priority over stop.
//    - STOP, data=0 (parity good): pulse oFrameError, clear both prefix flags, go to IDLE.
//  - Timeout:
//    - Counter clears on every fall and in IDLE.
//    - In any other state, reaching TIMEOUT_CYCLES-1 pulses oFrameError, clears prefix flags, forces IDLE and discards the partial byte.
//  - Byte complete:
//    - E0 sets the ext flag; F0 sets the brk flag; no event is produced for either.
//    - Any other byte is an event: {code, ext, brk}. Both flags clear in that cycle.
//  - Output register:
//    - oValid, oCode, oExtended and oBreak update 1 cycle after the STOP-sampling cycle.
//    - Held stable while oValid=1 and iReady=0.
//    - Event arrives while oValid=1 and iReady=0: the new event is dropped and oOverrun pulses.
//    - Event arrives while oValid=1 and iReady=1: the old event is accepted and the new one loads (oValid stays 1).
//    - No event and oValid & iReady: oValid goes to 0 next cycle.
//  - oBusy=1 in DATA, PARITY and STOP.
// TESTING
//  1. Frame 0,[1,1,0,1,0,0,0,1],p=1,stop=1; iReady=1
//     -> one event oCode=8'h8B, oExtended=0, oBreak=0; no error pulses.
//  2. Frames E0, F0, 75 back-to-back
//     -> exactly one event oCode=8'h75, oExtended=1, oBreak=1; the following 0F gives flags 0.
//  3. Frame data 8'h61 with p=1 (even total)
//     -> oParityError pulses once; no oValid; next valid frame 8'h0F delivered normally.
//  4. Start + 5 data bits, then keyboard clock held high
//     -> oFrameError after TIMEOUT_CYCLES; oBusy=0; next frame 8'h0F received correctly.
//  5. iReady=0; frames 8B then 0F
//     -> oCode holds 8B, oOverrun pulses at the 0F completion.
//     -> Raise iReady: 8B accepted, oValid drops, no 0F event.
//  6. iReset=0 at data bit 4 of a frame -> all outputs 0 next cycle.
//     1-cycle low glitch on iClockTeclado in IDLE -> ignored.
//     Then full frame 8'h8B -> delivered correctly.

Source files
------------

// File: rtl/ps2_frame_controller.sv
// PS/2 keyboard receiver: conditions the raw lines, frames 11-bit words, checks them,
// folds E0/F0 prefixes into flags and presents one key event at a time on a valid/ready port.
module ps2_frame_controller #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clock,
  input  logic       iReset,
  input  logic       iClockTeclado,
  input  logic       iDataTeclado,
  input  logic       iReady,
  output logic       oValid,
  output logic [7:0] oCode,
  output logic       oExtended,
  output logic       oBreak,
  output logic       oParityError,
  output logic       oFrameError,
  output logic       oOverrun,
  output logic       oBusy
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data byte plus its parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  state_t        state_r, state_next_s;
  logic [1:0]    kclk_sync_r, kdat_sync_r;
  logic          kclk_filt_r;
  logic [FW-1:0] filt_cnt_r;
  logic [7:0]    shift_r;
  logic [2:0]    bitcnt_r;
  logic          parity_r;
  logic [TW-1:0] tcnt_r;
  logic          ext_r, brk_r;
  logic          valid_r, ext_out_r, brk_out_r;
  logic [7:0]    code_r;
  logic          perr_r, ferr_r, ovr_r, busy_r;

  logic fall_s, dat_s, timeout_s;
  logic stop_seen_s, par_ok_s, parity_err_s, frame_err_s, byte_ok_s, event_s;
  logic is_e0_s, is_f0_s;

  assign dat_s     = kdat_sync_r[1];
  assign fall_s    = kclk_filt_r & ~kclk_sync_r[1] & (filt_cnt_r == FILT_LAST);
  assign timeout_s = (state_r != IDLE) & (tcnt_r == TO_LAST) & ~fall_s;

  // Two-flop synchronisers for the asynchronous keyboard lines.
  always_ff @(posedge Clock) begin
    if (!iReset) begin
      kclk_sync_r <= 2'b00;
      kdat_sync_r <= 2'b00;
    end else begin
      kclk_sync_r <= {kclk_sync_r[0], iClockTeclado};
      kdat_sync_r <= {kdat_sync_r[0], iDataTeclado};
    end
  end

  // Glitch filter: the keyboard clock flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge Clock) begin
    if (!iReset) begin
      kclk_filt_r <= 1'b0;
      filt_cnt_r  <= {FW{1'b0}};
    end else if (kclk_sync_r[1] != kclk_filt_r) begin
      if (filt_cnt_r == FILT_LAST) begin
        kclk_filt_r <= kclk_sync_r[1];
        filt_cnt_r  <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end else begin
      filt_cnt_r <= {FW{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (!iReset) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // FSM next-state logic; a timeout abandons any partial frame.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s && !dat_s) state_next_s = DATA;
        else                  state_next_s = IDLE;
      end
      DATA: begin
        if (timeout_s)                       state_next_s = IDLE;
        else if (fall_s && bitcnt_r == 3'd7) state_next_s = PARITY;
        else                                 state_next_s = DATA;
      end
      PARITY: begin
        if (timeout_s)   state_next_s = IDLE;
        else if (fall_s) state_next_s = STOP;
        else             state_next_s = PARITY;
      end
      STOP: begin
        if (timeout_s || fall_s) state_next_s = IDLE;
        else                     state_next_s = STOP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode: frame verdict in the cycle the stop bit is sampled.
  always_comb begin
    stop_seen_s  = 1'b0;
    par_ok_s     = odd_parity_ok(shift_r, parity_r);
    parity_err_s = 1'b0;
    frame_err_s  = timeout_s;
    byte_ok_s    = 1'b0;
    is_e0_s      = (shift_r == 8'hE0);
    is_f0_s      = (shift_r == 8'hF0);
    if (state_r == STOP && fall_s) begin
      stop_seen_s  = 1'b1;
      parity_err_s = ~par_ok_s;
      frame_err_s  = par_ok_s & ~dat_s;
      byte_ok_s    = par_ok_s & dat_s;
    end else begin
      stop_seen_s = 1'b0;
    end
    event_s = byte_ok_s & ~is_e0_s & ~is_f0_s;
  end

  // Shift register, bit counter, parity bit, inter-bit timeout and prefix flags.
  always_ff @(posedge Clock) begin
    if (!iReset) begin
      shift_r  <= 8'h00;
      bitcnt_r <= 3'd0;
      parity_r <= 1'b0;
      tcnt_r   <= {TW{1'b0}};
      ext_r    <= 1'b0;
      brk_r    <= 1'b0;
    end else begin
      if (state_r == IDLE || fall_s) tcnt_r <= {TW{1'b0}};
      else if (tcnt_r != TO_LAST)    tcnt_r <= tcnt_r + TW'(1);

      if (timeout_s) begin
        shift_r  <= 8'h00;
        bitcnt_r <= 3'd0;
      end else if (fall_s) begin
        case (state_r)
          IDLE: begin
            if (!dat_s) begin
              shift_r  <= 8'h00;
              bitcnt_r <= 3'd0;
            end
          end
          DATA: begin
            shift_r  <= {dat_s, shift_r[7:1]};
            bitcnt_r <= bitcnt_r + 3'd1;
          end
          PARITY:  parity_r <= dat_s;
          default: ;
        endcase
      end

      if (parity_err_s || frame_err_s || event_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end else if (byte_ok_s && is_e0_s) begin
        ext_r <= 1'b1;
      end else if (byte_ok_s && is_f0_s) begin
        brk_r <= 1'b1;
      end
    end
  end

  // Output register: holds an unaccepted event and drops newer ones as overruns.
  always_ff @(posedge Clock) begin
    if (!iReset) begin
      valid_r   <= 1'b0;
      code_r    <= 8'h00;
      ext_out_r <= 1'b0;
      brk_out_r <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      ovr_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      perr_r <= parity_err_s;
      ferr_r <= frame_err_s;
      ovr_r  <= 1'b0;
      busy_r <= (state_next_s != IDLE);
      if (event_s) begin
        if (valid_r && !iReady) begin
          ovr_r <= 1'b1;
        end else begin
          valid_r   <= 1'b1;
          code_r    <= shift_r;
          ext_out_r <= ext_r;
          brk_out_r <= brk_r;
        end
      end else if (valid_r && iReady) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign oValid       = valid_r;
  assign oCode        = code_r;
  assign oExtended    = ext_out_r;
  assign oBreak       = brk_out_r;
  assign oParityError = perr_r;
  assign oFrameError  = ferr_r;
  assign oOverrun     = ovr_r;
  assign oBusy        = busy_r;

endmodule

// File: tb/tb_ps2_frame_controller.sv
// Bench for ps2_frame_controller: directed scenarios plus random frames checked
// against a byte-level model of prefix folding, error reporting and output buffering.
module tb_ps2_frame_controller;

  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       Clock = 1'b0;
  logic       iReset = 1'b0;
  logic       kclk = 1'b1;
  logic       kdat = 1'b1;
  logic       iReady = 1'b1;
  logic       oValid, oExtended, oBreak, oParityError, oFrameError, oOverrun, oBusy;
  logic [7:0] oCode;

  int checks = 0;
  int errors = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int par_cnt = 0, frm_cnt = 0, ovr_cnt = 0;
  int exp_par = 0, exp_frm = 0, exp_ovr = 0;
  bit m_ext = 1'b0, m_brk = 1'b0, m_full = 1'b0;
  logic [9:0] m_slot = 10'd0;

  ps2_frame_controller #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .iReset(iReset), .iClockTeclado(kclk), .iDataTeclado(kdat),
    .iReady(iReady), .oValid(oValid), .oCode(oCode), .oExtended(oExtended),
    .oBreak(oBreak), .oParityError(oParityError), .oFrameError(oFrameError),
    .oOverrun(oOverrun), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  // Record every handshake and every error pulse, sampled mid-cycle.
  always @(negedge Clock) begin
    if (oValid && iReady) got_q.push_back({oCode, oExtended, oBreak});
    if (oParityError) par_cnt++;
    if (oFrameError)  frm_cnt++;
    if (oOverrun)     ovr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    kdat = b;
    tick(HALF);
    kclk = 1'b0;
    tick(HALF);
    kclk = 1'b1;
  endtask

  // Model: what one received byte means at the event level.
  task automatic model_deliver(input logic [9:0] ev);
    if (iReady) exp_q.push_back(ev);
    else if (m_full) exp_ovr++;
    else begin
      m_full = 1'b1;
      m_slot = ev;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit stop_b);
    if (bad_par) begin
      exp_par++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (!stop_b) begin
      exp_frm++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      model_deliver({b, m_ext, m_brk});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(stop_b);
    kdat = 1'b1;
    tick(HALF);
    model_byte(b, bad_par, stop_b);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
  endtask

  task automatic raise_ready();
    iReady = 1'b1;
    if (m_full) exp_q.push_back(m_slot);
    m_full = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_event"}, got_q[i], exp_q[i]);
    check({tag, "_parerr"}, par_cnt, exp_par);
    check({tag, "_frmerr"}, frm_cnt, exp_frm);
    check({tag, "_overrun"}, ovr_cnt, exp_ovr);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] b;
    int r;

    // Reset state
    tick(3);
    check("reset_outputs", {oValid, oCode, oExtended, oBreak, oParityError, oFrameError, oOverrun, oBusy}, 32'd0);
    iReset = 1'b1;
    tick(20);

    // 1: single plain frame
    send_frame(8'h8B, 1'b0, 1'b1);
    compare_all("t1");

    // 2: E0 F0 75 then 0F
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1);
    compare_all("t2");

    // 3: bad parity then good frame
    send_frame(8'h61, 1'b1, 1'b1);
    compare_all("t3_bad");
    send_frame(8'h0F, 1'b0, 1'b1);
    compare_all("t3_good");

    // 4: pending E0, then partial frame abandoned -> timeout clears the prefix
    send_frame(8'hE0, 1'b0, 1'b1);
    send_partial(8'h55, 5);
    check("t4_busy_mid", oBusy, 1'b1);
    n = HALF;
    while (!oFrameError && n < TO + 60) begin
      tick(1);
      n++;
    end
    check("t4_timeout_window", (n >= TO) && (n <= TO + 20), 1'b1);
    exp_frm++; m_ext = 1'b0; m_brk = 1'b0;
    tick(2);
    check("t4_busy_after", oBusy, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1);
    compare_all("t4");

    // 5: back-pressure and overrun
    iReady = 1'b0;
    send_frame(8'h8B, 1'b0, 1'b1);
    check("t5_valid_held", oValid, 1'b1);
    check("t5_code_held", oCode, 8'h8B);
    send_frame(8'h0F, 1'b0, 1'b1);
    check("t5_code_after_overrun", oCode, 8'h8B);
    raise_ready();
    tick(3);
    check("t5_valid_drop", oValid, 1'b0);
    compare_all("t5");

    // 6: reset mid-frame with a held event and a pending prefix
    iReady = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_partial(8'hA5, 4);
    kdat = 1'b0;
    tick(HALF / 2);
    iReset = 1'b0;
    tick(1);
    check("t6_reset_outputs", {oValid, oCode, oExtended, oBreak, oParityError, oFrameError, oOverrun, oBusy}, 32'd0);
    iReset = 1'b1;
    kdat = 1'b1;
    m_full = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    iReady = 1'b1;
    tick(20);
    kdat = 1'b0; kclk = 1'b0;
    tick(1);
    kclk = 1'b1;
    tick(10);
    kclk = 1'b0;
    tick(3);
    kclk = 1'b1; kdat = 1'b1;
    tick(20);
    check("t6_glitch_ignored", oBusy, 1'b0);
    send_frame(8'h8B, 1'b0, 1'b1);
    compare_all("t6");

    // Random frames with prefixes, parity and stop faults
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else             b = 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0));
    end
    compare_all("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
